// File: rtl/cmp_pkg.sv
// Shared compare-mode encodings (branch funct3), FSM state enum and result helpers.
package cmp_pkg;

  localparam logic [2:0] MODE_EQ  = 3'b000;
  localparam logic [2:0] MODE_NE  = 3'b001;
  localparam logic [2:0] MODE_R2  = 3'b010;
  localparam logic [2:0] MODE_R3  = 3'b011;
  localparam logic [2:0] MODE_LT  = 3'b100;
  localparam logic [2:0] MODE_GE  = 3'b101;
  localparam logic [2:0] MODE_LTU = 3'b110;
  localparam logic [2:0] MODE_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic mode_is_signed(input logic [2:0] m);
    return (m == MODE_LT) || (m == MODE_GE);
  endfunction

  function automatic logic mode_result(input logic [2:0] m, input logic eq, input logic lt);
    logic r;
    case (m)
      MODE_EQ:           r = eq;
      MODE_NE:           r = ~eq;
      MODE_LT, MODE_LTU: r = lt;
      MODE_GE, MODE_GEU: r = ~lt;
      MODE_R2, MODE_R3:  r = 1'b0;
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Unsigned equality / less-than of two W-bit slices.
// Latency: combinational. Backpressure: none.
module cmp_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         eq,
  output logic         lt
);

  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/cmp_seq.sv
// Sequential MSB-first chunked comparator; CMP_SEQ_EARLY_EXIT_EN stops at first differing chunk.
// Latency: N cycles accept->out_valid (early exit: position of first differing chunk).
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             q
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KMAX = KW'(N - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       mode_r;
  logic [KW-1:0]    k;
  logic             pfx_eq, pfx_lt, q_r;
  logic [CHUNK-1:0] flip, sa, sb;
  logic             c_eq, c_lt, r_eq, r_lt, last;

  // Flipping the sign bit of the top chunk turns signed ordering into unsigned ordering.
  always_comb begin
    flip            = '0;
    flip[CHUNK-1]   = (k == KMAX) && mode_is_signed(mode_r);
    sa              = a_r[k*CHUNK +: CHUNK] ^ flip;
    sb              = b_r[k*CHUNK +: CHUNK] ^ flip;
  end

  cmp_chunk #(.W(CHUNK)) u_chunk (
    .x  (sa),
    .y  (sb),
    .eq (c_eq),
    .lt (c_lt)
  );

  // The first differing chunk from the MSB decides lt; later chunks only matter while equal.
  assign r_eq = pfx_eq & c_eq;
  assign r_lt = pfx_eq ? c_lt : pfx_lt;

`ifdef CMP_SEQ_EARLY_EXIT_EN
  assign last = (k == '0) || !r_eq;
`else
  assign last = (k == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= '0;
      k      <= '0;
      pfx_eq <= 1'b0;
      pfx_lt <= 1'b0;
      q_r    <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= mode;
      k      <= KMAX;
      pfx_eq <= 1'b1;
      pfx_lt <= 1'b0;
    end else if (state == RUN) begin
      pfx_eq <= r_eq;
      pfx_lt <= r_lt;
      if (last) q_r <= mode_result(mode_r, r_eq, r_lt);
      else      k   <= k - KW'(1);
    end
  end

  assign q = q_r;

endmodule

// File: tb/tb_cmp_seq.sv
// Directed + scoreboard bench for cmp_seq (WIDTH=32, CHUNK=8), both early-exit builds.
module tb_cmp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [2:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic        q;

  int n_cmp = 0;
  int n_err = 0;

  bit exp_q_sb[$];
  int exp_lat_sb[$];

  always #5 clk = ~clk;

  cmp_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  function automatic bit model_q(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    case (m)
      3'b000: return x == y;
      3'b001: return x != y;
      3'b100: return $signed(x) < $signed(y);
      3'b101: return $signed(x) >= $signed(y);
      3'b110: return x < y;
      3'b111: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef CMP_SEQ_EARLY_EXIT_EN
    for (int j = 0; j < 4; j++)
      if (x[31-8*j -: 8] != y[31-8*j -: 8]) return j + 1;
`endif
    return 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [2:0] tm, input int hold);
    int  lat;
    bit  eq_q;
    int  e_lat;
    @(negedge clk);
    check({tag, " in_ready idle"}, in_ready, 1);
    a = ta; b = tb; mode = tm; in_valid = 1'b1;
    exp_q_sb.push_back(model_q(ta, tb, tm));
    exp_lat_sb.push_back(model_lat(ta, tb));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta; b = ta ^ 32'h5A5A_A5A5; mode = ~tm;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      a = a + 32'h0101_0101; b = ~b;
    end while (!out_valid && lat < 20);
    check({tag, " out_valid timeout"}, out_valid, 1);
    if (exp_q_sb.size() == 0) begin
      $display("FAIL %s scoreboard empty", tag);
      n_err++;
    end else begin
      eq_q  = exp_q_sb.pop_front();
      e_lat = exp_lat_sb.pop_front();
      check({tag, " q"}, q, eq_q);
      check({tag, " latency"}, lat, e_lat);
      for (int h = 0; h < hold; h++) begin
        mode = mode + 3'd1; a = ~a;
        @(negedge clk);
        check({tag, " hold out_valid"}, out_valid, 1);
        check({tag, " hold q"}, q, eq_q);
        check({tag, " hold in_ready"}, in_ready, 0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " in_ready after handshake"}, in_ready, 1);
    check({tag, " out_valid after handshake"}, out_valid, 0);
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = '0;
    #3;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset q", q, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int m = 0; m < 8; m++)
      do_req($sformatf("fe_ff m%0d", m), 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'(m), 0);

    do_req("msb slt", 32'h8000_0000, 32'h0000_0001, 3'b100, 0);
    do_req("msb ltu", 32'h8000_0000, 32'h0000_0001, 3'b110, 0);

    do_req("backpressure", 32'h1234_5678, 32'h1234_5678, 3'b000, 3);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = ra ^ (32'h1 << $urandom_range(31, 0));
      do_req($sformatf("rand%0d", i), ra, rb, 3'($urandom_range(7, 0)), i % 2);
    end

    // Abandon an operation in its second RUN cycle.
    @(negedge clk);
    a = 32'h0F0F_0F0F; b = 32'h0F0F_0F0F; mode = 3'b000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun rst in_ready", in_ready, 1);
    check("midrun rst out_valid", out_valid, 0);
    check("midrun rst q", q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no spurious out_valid", seen, 0);
    do_req("post reset", 32'h7000_0000, 32'h8000_0000, 3'b100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_seq.md
CMP_SEQ -- requirements
Module: cmp_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter CHUNK, default 8: bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 mode  input  3  compare mode, branch funct3 encoding.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 q  output  1  comparison result.

Function
REQ-013 Mode results SHALL be:
- 000: a==b
- 001: a!=b
- 100: a<b signed
- 101: a>=b signed
- 110: a<b unsigned
- 111: a>=b unsigned
- 010 and 011: q=0.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; when in_valid=1, latch a, b and mode, set chunk index k=N-1 (the MSB chunk), and go to RUN.
REQ-016 RUN: compare chunk k of the latched operands each cycle; in_ready=0.
- In chunk N-1, for signed modes, invert the sign bit of both operands before comparing.
REQ-017 RUN exit: when k=0, or on a differing chunk if early exit is enabled, register eq/lt and go to DONE; otherwise decrement k.
REQ-018 DONE: out_valid=1 and q stable; on out_ready=1 go to IDLE.
- in_ready stays 0 in DONE, so there is no same-cycle accept.
REQ-019 Latency, counted from the accept edge to the out_valid assertion edge, SHALL be N cycles when early exit is disabled.
REQ-020 With early exit enabled, latency SHALL be j, where j is the 1-based position from the MSB of the first differing chunk; if all chunks are equal, latency is N.
REQ-021 Inputs a, b and mode SHALL be ignored outside the IDLE accept cycle.
- Changing them during RUN or DONE SHALL NOT affect q.
REQ-022 N=1 SHALL be supported: result in 1 cycle.

Reset
REQ-023 While rst_n=0 the outputs SHALL be: state=IDLE, in_ready=1, out_valid=0, q=0, k=0.
- This applies immediately and independent of clk.
REQ-024 Reset asserted during RUN or DONE SHALL abandon the operation without emitting a result; the first post-reset accept SHALL behave normally.

Configuration
REQ-025 Macro CMP_SEQ_EARLY_EXIT_EN defined: RUN SHALL terminate on the first differing chunk.
- Undefined: RUN SHALL always take N cycles.
- q SHALL be identical in both builds.

Structure
REQ-026 Shared package cmp_pkg SHALL hold:
- the mode encoding constants for all eight funct3 values
- the state enum (IDLE, RUN, DONE).
REQ-027 Combinational sub-module cmp_chunk SHALL take two CHUNK-bit slices and return eq and lt (unsigned); cmp_seq SHALL instantiate it once.

Verification (WIDTH=32, CHUNK=8)
REQ-028 a=0xFFFFFFFE, b=0xFFFFFFFF, each mode 0..7 in turn:
- q = 0,1,0,0,1,0,1,0
- latency 4 in both builds.
REQ-029 a=0x80000000, b=0x00000001:
- mode 100 -> q=1; mode 110 -> q=0.
- Latency 1 with CMP_SEQ_EARLY_EXIT_EN, 4 without.
REQ-030 Backpressure: a=b=0x12345678, mode 000, out_ready held low 3 cycles after out_valid.
- out_valid=1 and q=1 are held throughout; in_ready=0.
- in_ready returns to 1 the cycle after the out_ready handshake.
REQ-031 Mid-RUN: a and b change during RUN; the result SHALL reflect the latched values.
REQ-032 Reset mid-RUN: assert rst_n=0 in cycle 2 of RUN.
- in_ready=1 and out_valid=0 immediately.
- No spurious out_valid after release.
- The next request completes correctly.
